// File: rtl/sram_pkg.sv
// Shared SRAM geometry, read latency and scheduler state encoding.
package sram_pkg;

    localparam int SRAM_ADDR_COUNT = 20;  // word address width
    localparam int SRAM_DATA_WIDTH = 16;
    localparam int SRAM_RD_LAT     = 2;
    localparam int SRAM_LEN_W      = 10;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } SchedState;

endpackage

// File: rtl/rd_tag_pipe.sv
// RD_LAT-deep shift register of {valid, index} tracking aux reads in flight.
module rd_tag_pipe #(
    parameter int RD_LAT = 2,
    parameter int IDX_W  = 10
) (
    input  logic             i_clk,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [IDX_W-1:0] i_index,
    output logic             o_valid,
    output logic [IDX_W-1:0] o_index,
    output logic             o_busy
);

    logic [RD_LAT-1:0]            vld_q;
    logic [RD_LAT-1:0][IDX_W-1:0] idx_q;

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            vld_q <= '0;
            idx_q <= '0;
        end else begin
            vld_q[0] <= i_load;
            idx_q[0] <= i_load ? i_index : '0;
            for (int s = 1; s < RD_LAT; s++) begin
                vld_q[s] <= vld_q[s-1];
                idx_q[s] <= idx_q[s-1];
            end
        end
    end

    assign o_valid = vld_q[RD_LAT-1];
    assign o_index = idx_q[RD_LAT-1];
    assign o_busy  = |vld_q;

endmodule

// File: rtl/sram_read_scheduler.sv
// Shares the SRAM read port: display has absolute priority, aux bursts fill idle slots.
// Define SRAM_SCHED_STATS_EN to add the o_preempt_cnt preemption counter.
module sram_read_scheduler
    import sram_pkg::*;
#(
    parameter int ADDR_W = SRAM_ADDR_COUNT,
    parameter int DATA_W = SRAM_DATA_WIDTH,
    parameter int RD_LAT = SRAM_RD_LAT,
    parameter int LEN_W  = SRAM_LEN_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_disp_en,
    input  logic [ADDR_W-1:0] i_disp_addr,
    input  logic              i_aux_start,
    input  logic [ADDR_W-1:0] i_aux_base,
    input  logic [LEN_W-1:0]  i_aux_len,
    output logic              o_aux_busy,
    output logic              o_aux_rvalid,
    output logic [DATA_W-1:0] o_aux_rdata,
    output logic [LEN_W-1:0]  o_aux_rindex,
    output logic              o_aux_done,
`ifdef SRAM_SCHED_STATS_EN
    output logic [15:0]       o_preempt_cnt,
`endif
    output logic [ADDR_W-1:0] o_sram_addr,
    input  logic [DATA_W-1:0] i_sram_data
);

    SchedState         state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  idx_q, idx_d;
    logic              pending;
    logic              issue;
    logic              pipe_busy;
    logic              pipe_valid;
    logic [LEN_W-1:0]  pipe_index;

    assign pending = (state_q == ISSUE) && (idx_q < len_q);
    assign issue   = pending && !i_disp_en;

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        len_d   = len_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (i_aux_start) begin
                    base_d  = i_aux_base;
                    len_d   = i_aux_len;
                    idx_d   = '0;
                    state_d = (i_aux_len == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (issue) begin
                    idx_d = idx_q + LEN_W'(1);
                    if (idx_q == len_q - LEN_W'(1)) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!pipe_busy) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            base_q  <= '0;
            len_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
        end
    end

    // Display address passes straight through; aux address wraps modulo 2^ADDR_W.
    always_comb begin
        o_sram_addr = '0;
        if (i_disp_en)    o_sram_addr = i_disp_addr;
        else if (pending) o_sram_addr = base_q + ADDR_W'(idx_q);
    end

    rd_tag_pipe #(
        .RD_LAT (RD_LAT),
        .IDX_W  (LEN_W)
    ) u_tag_pipe (
        .i_clk   (i_clk),
        .i_clr   (i_rst),
        .i_load  (issue),
        .i_index (idx_q),
        .o_valid (pipe_valid),
        .o_index (pipe_index),
        .o_busy  (pipe_busy)
    );

    // The tag's last stage lines up with the SRAM data of the same read.
    assign o_aux_rvalid = pipe_valid;
    assign o_aux_rindex = pipe_index;
    assign o_aux_rdata  = pipe_valid ? i_sram_data : '0;
    assign o_aux_busy   = (state_q != IDLE);
    assign o_aux_done   = (state_q == DONE);

`ifdef SRAM_SCHED_STATS_EN
    logic [15:0] preempt_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            preempt_q <= '0;
        end else if (state_q == IDLE && i_aux_start) begin
            preempt_q <= '0;
        end else if (pending && i_disp_en && preempt_q != 16'hFFFF) begin
            preempt_q <= preempt_q + 16'd1;
        end
    end

    assign o_preempt_cnt = preempt_q;
`endif

endmodule

// File: tb/tb_sram_read_scheduler.sv
// Directed bench for sram_read_scheduler with a 2-cycle SRAM model (data = addr[15:0]^0x5A5A).
module tb_sram_read_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        den;
    logic [19:0] daddr;
    logic        st;
    logic [19:0] base;
    logic [9:0]  len;
    logic        busy, rvalid, done;
    logic [15:0] rdata;
    logic [9:0]  rindex;
    logic [19:0] sram_addr;
    logic [15:0] sram_data;
`ifdef SRAM_SCHED_STATS_EN
    logic [15:0] preempt_cnt;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sram_read_scheduler dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_disp_en    (den),
        .i_disp_addr  (daddr),
        .i_aux_start  (st),
        .i_aux_base   (base),
        .i_aux_len    (len),
        .o_aux_busy   (busy),
        .o_aux_rvalid (rvalid),
        .o_aux_rdata  (rdata),
        .o_aux_rindex (rindex),
        .o_aux_done   (done),
`ifdef SRAM_SCHED_STATS_EN
        .o_preempt_cnt(preempt_cnt),
`endif
        .o_sram_addr  (sram_addr),
        .i_sram_data  (sram_data)
    );

    // SRAM model: data for the address driven in cycle t appears in cycle t+2.
    logic [19:0] a1 = '0, a2 = '0;
    always @(posedge clk) begin
        a1 <= sram_addr;
        a2 <= a1;
    end
    assign sram_data = a2[15:0] ^ 16'h5A5A;

    typedef struct {
        logic [9:0]  idx;
        logic [15:0] data;
    } beat_t;
    beat_t beats[$];
    int    done_cnt = 0;

    always @(negedge clk) begin
        if (rvalid) beats.push_back('{rindex, rdata});
        if (done) done_cnt++;
    end

    typedef struct {
        logic        den;
        logic [19:0] daddr;
        logic        st;
        logic [19:0] base;
        logic [9:0]  len;
        logic [19:0] eaddr;
        logic        erv;
        logic [9:0]  eidx;
        logic [15:0] edata;
        logic        edone;
        logic        ebusy;
    } vec_t;
    vec_t tbl[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_mon();
        beats.delete();
        done_cnt = 0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 60) begin
            nxt();
            n++;
        end
        chk("idle_timeout", 32'(busy), 32'd0);
        repeat (2) nxt();
    endtask

    task automatic chk_beats(input logic [19:0] b, input int n);
        logic [19:0] a;
        chk("beat_cnt", 32'(beats.size()), 32'(n));
        chk("done_cnt", 32'(done_cnt), 32'd1);
        for (int i = 0; i < beats.size() && i < n; i++) begin
            a = b + 20'(i);
            chk("beat_idx", 32'(beats[i].idx), 32'(i));
            chk("beat_data", 32'(beats[i].data), 32'(a[15:0] ^ 16'h5A5A));
        end
    endtask

    task automatic start(input logic [19:0] b, input logic [9:0] l);
        st = 1'b1; base = b; len = l;
        nxt();
        st = 1'b0;
    endtask

    initial begin
        logic [19:0] pa[12];
        logic        prv[12];

        // den daddr st base len | eaddr rv idx data done busy
        tbl[0]  = '{1'b1, 20'h12345, 1'b0, 20'h0,   10'd0, 20'h12345, 1'b0, 10'd0, 16'h0,    1'b0, 1'b0};
        tbl[1]  = '{1'b0, 20'h12345, 1'b0, 20'h0,   10'd0, 20'h00000, 1'b0, 10'd0, 16'h0,    1'b0, 1'b0};
        tbl[2]  = '{1'b0, 20'h0,     1'b1, 20'h100, 10'd4, 20'h00000, 1'b0, 10'd0, 16'h0,    1'b0, 1'b0};
        tbl[3]  = '{1'b0, 20'h0,     1'b0, 20'h0,   10'd0, 20'h00100, 1'b0, 10'd0, 16'h0,    1'b0, 1'b1};
        tbl[4]  = '{1'b0, 20'h0,     1'b0, 20'h0,   10'd0, 20'h00101, 1'b0, 10'd0, 16'h0,    1'b0, 1'b1};
        tbl[5]  = '{1'b0, 20'h0,     1'b0, 20'h0,   10'd0, 20'h00102, 1'b1, 10'd0, 16'h5B5A, 1'b0, 1'b1};
        tbl[6]  = '{1'b0, 20'h0,     1'b0, 20'h0,   10'd0, 20'h00103, 1'b1, 10'd1, 16'h5B5B, 1'b0, 1'b1};
        tbl[7]  = '{1'b0, 20'h0,     1'b0, 20'h0,   10'd0, 20'h00000, 1'b1, 10'd2, 16'h5B58, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 20'h0,     1'b0, 20'h0,   10'd0, 20'h00000, 1'b1, 10'd3, 16'h5B59, 1'b0, 1'b1};
        tbl[9]  = '{1'b0, 20'h0,     1'b0, 20'h0,   10'd0, 20'h00000, 1'b0, 10'd0, 16'h0,    1'b0, 1'b1};
        tbl[10] = '{1'b0, 20'h0,     1'b0, 20'h0,   10'd0, 20'h00000, 1'b0, 10'd0, 16'h0,    1'b1, 1'b1};
        tbl[11] = '{1'b0, 20'h0,     1'b0, 20'h0,   10'd0, 20'h00000, 1'b0, 10'd0, 16'h0,    1'b0, 1'b0};

        rst = 1'b1; den = 1'b0; daddr = '0; st = 1'b0; base = '0; len = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state, display pass-through and a clean len=4 burst.
        for (int i = 0; i < 12; i++) begin
            den = tbl[i].den; daddr = tbl[i].daddr; st = tbl[i].st;
            base = tbl[i].base; len = tbl[i].len;
            @(negedge clk);
            chk($sformatf("v%0d_addr", i),  32'(sram_addr), 32'(tbl[i].eaddr));
            chk($sformatf("v%0d_rv", i),    32'(rvalid),    32'(tbl[i].erv));
            chk($sformatf("v%0d_idx", i),   32'(rindex),    32'(tbl[i].eidx));
            chk($sformatf("v%0d_data", i),  32'(rdata),     32'(tbl[i].edata));
            chk($sformatf("v%0d_done", i),  32'(done),      32'(tbl[i].edone));
            chk($sformatf("v%0d_busy", i),  32'(busy),      32'(tbl[i].ebusy));
            nxt();
        end
        den = 1'b0; st = 1'b0;
        repeat (2) nxt();

        // Display preempts three slots after the second aux issue.
        pa  = '{20'h0, 20'h100, 20'h101, 20'hABCDE, 20'hABCDE, 20'hABCDE, 20'h102, 20'h103, 20'h0, 20'h0, 20'h0, 20'h0};
        prv = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        clr_mon();
        start(20'h100, 10'd4);
        for (int c = 1; c < 12; c++) begin
            den = (c >= 3 && c <= 5); daddr = 20'hABCDE;
            @(negedge clk);
            if (c <= 7) chk($sformatf("pause_addr%0d", c), 32'(sram_addr), 32'(pa[c]));
            if (c <= 9) chk($sformatf("pause_rv%0d", c), 32'(rvalid), 32'(prv[c]));
            nxt();
        end
        den = 1'b0;
        wait_idle();
        chk_beats(20'h100, 4);

        // Address wrap, with a start pulse during the burst that must be ignored.
        clr_mon();
        start(20'hFFFFE, 10'd3);
        @(negedge clk); chk("wrap_a0", 32'(sram_addr), 32'h000FFFFE);
        nxt();
        st = 1'b1; base = 20'h55555; len = 10'd7;
        @(negedge clk); chk("wrap_a1", 32'(sram_addr), 32'h000FFFFF);
        nxt();
        st = 1'b0;
        @(negedge clk); chk("wrap_a2", 32'(sram_addr), 32'h00000000);
        nxt();
        wait_idle();
        chk_beats(20'hFFFFE, 3);

        // Zero-length burst: done the next cycle, no reads.
        clr_mon();
        st = 1'b1; base = 20'h40; len = 10'd0;
        @(negedge clk); chk("len0_busy0", 32'(busy), 32'd0);
        nxt(); st = 1'b0;
        @(negedge clk);
        chk("len0_done", 32'(done), 32'd1);
        chk("len0_addr", 32'(sram_addr), 32'd0);
        nxt();
        @(negedge clk);
        chk("len0_done_off", 32'(done), 32'd0);
        chk("len0_busy_off", 32'(busy), 32'd0);
        repeat (3) nxt();
        chk("len0_beats", 32'(beats.size()), 32'd0);
        chk("len0_done_cnt", 32'(done_cnt), 32'd1);

        // Reset after two of five beats issued abandons the burst.
        clr_mon();
        start(20'h200, 10'd5);
        nxt(); nxt();
        rst = 1'b1;
        nxt();
        rst = 1'b0;
        clr_mon();
        repeat (10) nxt();
        chk("rst_beats", 32'(beats.size()), 32'd0);
        chk("rst_done", 32'(done_cnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        clr_mon();
        start(20'h300, 10'd2);
        wait_idle();
        chk_beats(20'h300, 2);

`ifdef SRAM_SCHED_STATS_EN
        clr_mon();
        start(20'h400, 10'd8);
        for (int c = 0; c < 5; c++) begin
            den = 1'b1; daddr = 20'h777;
            nxt();
        end
        den = 1'b0;
        wait_idle();
        chk_beats(20'h400, 8);
        chk("preempt_cnt", 32'(preempt_cnt), 32'd5);
        clr_mon();
        start(20'h0, 10'd1);
        @(negedge clk); chk("preempt_clr", 32'(preempt_cnt), 32'd0);
        wait_idle();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
